// File: rtl/spike_rate_counter.sv
// Spike event counter: edge detect with refractory lockout, fixed-length counting windows,
// valid/ready result hand-off. Define SPIKE_ISI_EN to add minimum inter-spike-interval output.
module spike_rate_counter #(
    parameter int unsigned WIN_LEN = 1000,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned REFRACT = 4,
    parameter int unsigned ISI_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_spike,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_count,
    output logic             o_count_valid,
    input  logic             i_count_ready,
    output logic             o_overrun
`ifdef SPIKE_ISI_EN
    ,
    output logic [ISI_W-1:0] o_isi_min
`endif
);

    localparam int unsigned WinW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int unsigned RefW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [WinW-1:0]  WinLast = WinW'(WIN_LEN - 1);
    localparam logic [RefW-1:0]  RefLoad = RefW'(REFRACT);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e           r_state, w_state_nxt;
    logic             r_spike_d;
    logic [RefW-1:0]  r_refr;
    logic [WinW-1:0]  r_win;
    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_overrun, w_overrun_nxt;
    logic             w_load;
    logic             w_edge, w_event, w_close;
    logic [CNT_W-1:0] w_result;

    assign w_edge   = i_spike & ~r_spike_d;
    // clear suppresses any edge and any window close in its cycle
    assign w_event  = w_edge & (r_refr == '0) & ~i_clear;
    assign w_close  = (r_win == WinLast) & ~i_clear;
    assign w_result = (r_acc == CntMax) ? CntMax : r_acc + CNT_W'(w_event);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_spike_d <= 1'b0;
            r_refr    <= '0;
            r_win     <= '0;
            r_acc     <= '0;
        end else begin
            r_spike_d <= i_spike;
            if (i_clear) begin
                r_refr <= '0;
                r_win  <= '0;
                r_acc  <= '0;
            end else begin
                if (w_event) begin
                    r_refr <= RefLoad;
                end else if (r_refr != '0) begin
                    r_refr <= r_refr - 1'b1;
                end
                r_win <= w_close ? '0 : r_win + 1'b1;
                r_acc <= w_close ? '0 : w_result;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_overrun_nxt = r_overrun;
        w_load        = 1'b0;
        if (i_clear) begin
            w_state_nxt   = StEmpty;
            w_overrun_nxt = 1'b0;
        end else begin
            unique case (r_state)
                StEmpty: begin
                    if (w_close) begin
                        w_load      = 1'b1;
                        w_state_nxt = StFull;
                    end
                end
                StFull: begin
                    if (i_count_ready) begin
                        if (w_close) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = StEmpty;
                        end
                    end else if (w_close) begin
                        w_overrun_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = StEmpty;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StEmpty;
            r_overrun <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_overrun <= w_overrun_nxt;
            if (w_load) begin
                r_count <= w_result;
            end
        end
    end

    assign o_count       = r_count;
    assign o_count_valid = (r_state == StFull);
    assign o_overrun     = r_overrun;

`ifdef SPIKE_ISI_EN
    localparam logic [ISI_W-1:0] IsiMax = '1;

    logic [ISI_W-1:0] r_isi_cnt, r_min_acc, r_isi_min, w_min_new;
    logic             r_seen;

    // min including an event in this very cycle, so a close-cycle event is not lost
    always_comb begin
        w_min_new = r_min_acc;
        if (w_event && r_seen && (r_isi_cnt < r_min_acc)) begin
            w_min_new = r_isi_cnt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_isi_cnt <= '0;
            r_min_acc <= IsiMax;
            r_isi_min <= IsiMax;
            r_seen    <= 1'b0;
        end else if (i_clear) begin
            r_isi_cnt <= '0;
            r_min_acc <= IsiMax;
            r_seen    <= 1'b0;
        end else begin
            if (w_event) begin
                r_isi_cnt <= ISI_W'(1);
                r_seen    <= 1'b1;
            end else if (r_isi_cnt != IsiMax) begin
                r_isi_cnt <= r_isi_cnt + 1'b1;
            end
            r_min_acc <= w_close ? IsiMax : w_min_new;
            if (w_load) begin
                r_isi_min <= w_min_new;
            end
        end
    end

    assign o_isi_min = r_isi_min;
`endif

endmodule

// File: tb/tb_spike_rate_counter.sv
// Bench for spike_rate_counter: two configurations driven in parallel and checked against an
// event-time reference model; directed scenarios followed by randomized traffic.
module tb_spike_rate_counter;

    localparam int WIN     = 16;
    localparam int ISI_MAX = 65535;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spike = 1'b0;
    logic       clear = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic       val_a, val_b, ovr_a, ovr_b;
`ifdef SPIKE_ISI_EN
    logic [15:0] isi_a, isi_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spike_rate_counter #(
        .WIN_LEN(WIN), .CNT_W(8), .REFRACT(4), .ISI_W(16)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_spike(spike), .i_clear(clear),
        .o_count(cnt_a), .o_count_valid(val_a), .i_count_ready(ready),
        .o_overrun(ovr_a)
`ifdef SPIKE_ISI_EN
        , .o_isi_min(isi_a)
`endif
    );

    spike_rate_counter #(
        .WIN_LEN(WIN), .CNT_W(2), .REFRACT(0), .ISI_W(16)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_spike(spike), .i_clear(clear),
        .o_count(cnt_b), .o_count_valid(val_b), .i_count_ready(ready),
        .o_overrun(ovr_b)
`ifdef SPIKE_ISI_EN
        , .o_isi_min(isi_b)
`endif
    );

    // Reference model: accepted events tracked by absolute cycle time, index 0 = dut_a, 1 = dut_b.
    int rf[2]   = '{4, 0};
    int cmax[2] = '{255, 3};
    int cyc, win_start, m_prev;
    int last_acc[2], last_ev[2], nev[2], minisi[2], m_count[2], m_isi[2];
    bit has_ev[2], m_valid[2], m_ovr[2];

    task automatic model_reset();
        cyc = 0;
        win_start = 0;
        m_prev = 0;
        for (int k = 0; k < 2; k++) begin
            last_acc[k] = -100;
            last_ev[k]  = 0;
            has_ev[k]   = 1'b0;
            nev[k]      = 0;
            minisi[k]   = ISI_MAX;
            m_count[k]  = 0;
            m_valid[k]  = 1'b0;
            m_ovr[k]    = 1'b0;
            m_isi[k]    = ISI_MAX;
        end
    endtask

    task automatic model_step();
        bit edge_seen, close, acc;
        int res, gap;
        edge_seen = spike && (m_prev == 0);
        close = !clear && (((cyc - win_start) % WIN) == WIN - 1);
        for (int k = 0; k < 2; k++) begin
            if (clear) begin
                last_acc[k] = -100;
                has_ev[k]   = 1'b0;
                nev[k]      = 0;
                minisi[k]   = ISI_MAX;
                m_valid[k]  = 1'b0;
                m_ovr[k]    = 1'b0;
            end else begin
                acc = edge_seen && (cyc - last_acc[k] > rf[k]);
                if (acc) begin
                    if (has_ev[k]) begin
                        gap = cyc - last_ev[k];
                        if (gap > ISI_MAX) gap = ISI_MAX;
                        if (gap < minisi[k]) minisi[k] = gap;
                    end
                    has_ev[k]   = 1'b1;
                    last_ev[k]  = cyc;
                    last_acc[k] = cyc;
                    nev[k]++;
                end
                if (close) begin
                    res = (nev[k] > cmax[k]) ? cmax[k] : nev[k];
                    if (!m_valid[k] || ready) begin
                        m_count[k] = res;
                        m_isi[k]   = minisi[k];
                        m_valid[k] = 1'b1;
                    end else begin
                        m_ovr[k] = 1'b1;
                    end
                    nev[k]    = 0;
                    minisi[k] = ISI_MAX;
                end else if (m_valid[k] && ready) begin
                    m_valid[k] = 1'b0;
                end
            end
        end
        if (clear) win_start = cyc + 1;
        m_prev = spike;
        cyc++;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ready = 1'b0;
        for (int i = 0; i < 38; i++) begin
            spike = (i % 2 == 0);
            step();
        end
        n_checks++;
        if (ovr_a !== m_ovr[0]) begin
            n_fail++; $display("FAIL reset_pre_ovr: got %0b want %0b", ovr_a, m_ovr[0]);
        end
        rst_n = 1'b0;
        #2;
        n_checks += 6;
        if (cnt_a !== 8'd0) begin n_fail++; $display("FAIL reset_cnt_a: got %0d want 0", cnt_a); end
        if (val_a !== 1'b0) begin n_fail++; $display("FAIL reset_val_a: got %0b want 0", val_a); end
        if (ovr_a !== 1'b0) begin n_fail++; $display("FAIL reset_ovr_a: got %0b want 0", ovr_a); end
        if (cnt_b !== 2'd0) begin n_fail++; $display("FAIL reset_cnt_b: got %0d want 0", cnt_b); end
        if (val_b !== 1'b0) begin n_fail++; $display("FAIL reset_val_b: got %0b want 0", val_b); end
        if (ovr_b !== 1'b0) begin n_fail++; $display("FAIL reset_ovr_b: got %0b want 0", ovr_b); end
`ifdef SPIKE_ISI_EN
        n_checks++;
        if (isi_a !== 16'hffff) begin n_fail++; $display("FAIL reset_isi: got %0d want 65535", isi_a); end
`endif
        spike = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single_spike();
        ready = 1'b0;
        for (int i = 0; i < WIN; i++) begin
            spike = (i >= 2 && i <= 6);
            step();
            if (i == WIN - 2) begin
                n_checks++;
                if (val_a !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %0b want 0", val_a); end
            end
        end
        n_checks += 3;
        if (cnt_a !== 8'd1) begin n_fail++; $display("FAIL single_cnt_a: got %0d want 1", cnt_a); end
        if (val_a !== 1'b1) begin n_fail++; $display("FAIL single_val_a: got %0b want 1", val_a); end
        if (cnt_b !== 2'd1) begin n_fail++; $display("FAIL single_cnt_b: got %0d want 1", cnt_b); end
    endtask

    task automatic test_toggle_saturation();
        for (int i = 0; i < WIN; i++) begin
            spike = (i % 2 == 0);
            ready = (i == 0);
            step();
        end
        ready = 1'b0;
        n_checks += 4;
        if (cnt_a !== 8'd3) begin n_fail++; $display("FAIL toggle_cnt_a: got %0d want 3", cnt_a); end
        if (val_a !== 1'b1) begin n_fail++; $display("FAIL toggle_val_a: got %0b want 1", val_a); end
        if (cnt_b !== 2'd3) begin n_fail++; $display("FAIL saturate_cnt_b: got %0d want 3", cnt_b); end
        if (ovr_a !== 1'b0) begin n_fail++; $display("FAIL toggle_ovr_a: got %0b want 0", ovr_a); end
`ifdef SPIKE_ISI_EN
        n_checks += 2;
        if (isi_a !== 16'd6) begin n_fail++; $display("FAIL toggle_isi_a: got %0d want 6", isi_a); end
        if (isi_b !== 16'd2) begin n_fail++; $display("FAIL toggle_isi_b: got %0d want 2", isi_b); end
`endif
    endtask

    task automatic test_backpressure();
        ready = 1'b0;
        for (int i = 0; i < WIN; i++) begin
            spike = (i % 4 == 0);
            step();
            if (i == 8) begin
                n_checks += 2;
                if (cnt_a !== 8'd3) begin n_fail++; $display("FAIL bp_stable_cnt: got %0d want 3", cnt_a); end
                if (val_a !== 1'b1) begin n_fail++; $display("FAIL bp_stable_val: got %0b want 1", val_a); end
            end
        end
        n_checks += 3;
        if (cnt_a !== 8'd3) begin n_fail++; $display("FAIL bp_held_cnt: got %0d want 3", cnt_a); end
        if (ovr_a !== 1'b1) begin n_fail++; $display("FAIL bp_ovr_a: got %0b want 1", ovr_a); end
        if (ovr_b !== 1'b1) begin n_fail++; $display("FAIL bp_ovr_b: got %0b want 1", ovr_b); end
        spike = 1'b0;
        ready = 1'b1;
        step();
        ready = 1'b0;
        n_checks += 3;
        if (val_a !== 1'b0) begin n_fail++; $display("FAIL bp_drain_val: got %0b want 0", val_a); end
        if (ovr_a !== 1'b1) begin n_fail++; $display("FAIL bp_sticky_ovr: got %0b want 1", ovr_a); end
        if (cnt_a !== 8'd3) begin n_fail++; $display("FAIL bp_drain_cnt: got %0d want 3", cnt_a); end
        repeat (4) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_checks += 2;
        if (ovr_a !== 1'b0) begin n_fail++; $display("FAIL bp_clear_ovr: got %0b want 0", ovr_a); end
        if (val_a !== 1'b0) begin n_fail++; $display("FAIL bp_clear_val: got %0b want 0", val_a); end
    endtask

    task automatic test_back_to_back();
        ready = 1'b0;
        for (int i = 0; i < WIN; i++) begin
            spike = (i == 3);
            step();
        end
        for (int i = 0; i < WIN; i++) begin
            spike = (i == 1 || i == 8);
            ready = (i == WIN - 1);
            step();
        end
        ready = 1'b0;
        n_checks += 3;
        if (cnt_a !== 8'd2) begin n_fail++; $display("FAIL b2b_cnt_a: got %0d want 2", cnt_a); end
        if (val_a !== 1'b1) begin n_fail++; $display("FAIL b2b_val_a: got %0b want 1", val_a); end
        if (ovr_a !== 1'b0) begin n_fail++; $display("FAIL b2b_ovr_a: got %0b want 0", ovr_a); end
        for (int i = 0; i < 7; i++) begin
            ready = (i == 0);
            spike = (i == 2 || i == 3 || i == 6);
            clear = (i == 6);
            step();
        end
        clear = 1'b0;
        ready = 1'b0;
        for (int j = 0; j < WIN; j++) begin
            spike = (j <= 1 || j == 9 || j == 10);
            step();
        end
        n_checks += 3;
        if (cnt_a !== 8'd1) begin n_fail++; $display("FAIL clear_cnt_a: got %0d want 1", cnt_a); end
        if (cnt_b !== 2'd1) begin n_fail++; $display("FAIL clear_cnt_b: got %0d want 1", cnt_b); end
        if (val_a !== 1'b1) begin n_fail++; $display("FAIL clear_val_a: got %0b want 1", val_a); end
`ifdef SPIKE_ISI_EN
        n_checks++;
        if (isi_a !== 16'hffff) begin n_fail++; $display("FAIL clear_isi_a: got %0d want 65535", isi_a); end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 2) == 0) spike = ~spike;
            ready = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
            if (i > 600) ready = ($urandom_range(0, 1) == 0);
            clear = ($urandom_range(0, 79) == 0);
            step();
            n_checks += 6;
            if (cnt_a !== 8'(m_count[0])) begin
                n_fail++; $display("FAIL rand_cnt_a @%0d: got %0d want %0d", i, cnt_a, m_count[0]);
            end
            if (val_a !== m_valid[0]) begin
                n_fail++; $display("FAIL rand_val_a @%0d: got %0b want %0b", i, val_a, m_valid[0]);
            end
            if (ovr_a !== m_ovr[0]) begin
                n_fail++; $display("FAIL rand_ovr_a @%0d: got %0b want %0b", i, ovr_a, m_ovr[0]);
            end
            if (cnt_b !== 2'(m_count[1])) begin
                n_fail++; $display("FAIL rand_cnt_b @%0d: got %0d want %0d", i, cnt_b, m_count[1]);
            end
            if (val_b !== m_valid[1]) begin
                n_fail++; $display("FAIL rand_val_b @%0d: got %0b want %0b", i, val_b, m_valid[1]);
            end
            if (ovr_b !== m_ovr[1]) begin
                n_fail++; $display("FAIL rand_ovr_b @%0d: got %0b want %0b", i, ovr_b, m_ovr[1]);
            end
`ifdef SPIKE_ISI_EN
            n_checks += 2;
            if (isi_a !== 16'(m_isi[0])) begin
                n_fail++; $display("FAIL rand_isi_a @%0d: got %0d want %0d", i, isi_a, m_isi[0]);
            end
            if (isi_b !== 16'(m_isi[1])) begin
                n_fail++; $display("FAIL rand_isi_b @%0d: got %0d want %0d", i, isi_b, m_isi[1]);
            end
`endif
        end
        clear = 1'b0;
        ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        test_reset();
        test_single_spike();
        test_toggle_saturation();
        test_backpressure();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
